barrel_shift_seq: RTL
=====================

// Module: barrel_shift_seq
// PURPOSE
//  Multi-cycle sequencer for the 8-bit barrel shifter datapath built from 4:1 mux levels.
//  - Accepts one shift command through a valid/ready handshake.
//  - Applies one mux level per clock: shift by 1, then by 2, then by 4, each gated by its bit of the shift amount.
//  - Holds the result under a valid/ready handshake until the consumer takes it.
//  - Sits between a command source (switch/keypad front end) and the display or result register.
// PARAMETERS
//  WIDTH  8  data width; must be a power of 2
//  SHW    3  shift-amount width; must equal log2(WIDTH); also the number of stage cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      sequencer can accept a command
//  cmd_data   in   WIDTH  operand
//  cmd_shamt  in   SHW    shift amount, 0..WIDTH-1
//  cmd_lr     in   1      1 = left, 0 = right
//  cmd_al     in   1      1 = arithmetic, 0 = logical; ignored for left shifts
//  flush      in   1      synchronous abort; forces IDLE
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes the result
//  res_data   out  WIDTH  shifted result
//  busy       out  1      high in STAGE or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, stage counter=0, work register=0.
//   - Outputs: res_valid=0, res_data=0, busy=0, cmd_ready=1 (combinational from IDLE).
//  FSM states: IDLE, STAGE, DONE.
//  IDLE:
//   - cmd_ready=1.
//   - On an edge with cmd_valid=1: latch cmd_data into work, latch shamt/lr/al; stage=0; go to STAGE.
//   - Otherwise remain in IDLE.
//  STAGE:
//   - cmd_ready=0. Each edge applies stage k (k = 0..SHW-1) to work.
//   - If shamt[k]=1, shift work by 2^k; if shamt[k]=0, work is unchanged.
//   - Fill bits: left shift fills LSBs with 0; right logical fills MSBs with 0; right arithmetic replicates work[WIDTH-1].
//   - The sign bit is the current work MSB. This equals the original MSB because each right shift replicates it.
//   - On the edge applying k=SHW-1: go to DONE, set res_valid=1, res_data=final work.
//  DONE:
//   - res_valid=1; res_data is held stable; cmd_ready=0, so commands are ignored.
//   - On an edge with res_ready=1: res_valid=0, go to IDLE. res_data keeps its last value.
//  Latency and throughput:
//   - Fixed latency for every shamt, including 0.
//   - Command accepted at edge E0 -> res_valid high after edge E0+SHW.
//   - Minimum spacing between accepts: SHW+2 cycles (5 for WIDTH=8). No accept in the same cycle as the result handshake.
//  flush:
//   - In STAGE or DONE: next state IDLE, res_valid=0, work discarded; res_data unchanged.
//   - In IDLE: flush has priority over cmd_valid, so no command is accepted that cycle.
//  Reset mid-operation: async return to reset values; no partial result is ever presented.
//  Width rules: shamt is unsigned; shifting out bits discards them; no rotate mode.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles, release -> res_valid=0, res_data=0, busy=0, cmd_ready=1.
//  2. Left shift: data=8'h96, shamt=3, lr=1 -> res_data=8'hB0 with res_valid rising exactly 3 edges after accept.
//  3. Right shifts: 8'h96 by 2 with al=1 -> 8'hE5; same with al=0 -> 8'h25; 8'h80 by 7 with al=1 -> 8'hFF.
//  4. shamt=0: data=8'h5A -> res_data=8'h5A, still 3-cycle latency; cmd_ready low throughout.
//  5. Backpressure: res_ready=0 for 4 cycles while cmd_valid=1 -> res_data stable, no second accept; after res_ready=1, IDLE, then the next command is accepted.
//  6. Abort: flush in the 2nd STAGE cycle -> IDLE next edge, res_valid stays 0; rst_n pulse during STAGE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/barrel_shift_seq_if.sv
// Command/result handshake bundle for the sequential barrel shifter.
// master = command source and result consumer, slave = sequencer.
interface barrel_shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [SHW-1:0]   cmd_shamt;
  logic             cmd_lr;
  logic             cmd_al;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_shamt, cmd_lr, cmd_al, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_shamt, cmd_lr, cmd_al, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/barrel_shift_seq.sv
// Multi-cycle barrel shifter: one log2 mux level (1, 2, 4, ...) per clock,
// command in and result out through valid/ready handshakes.
module barrel_shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  output logic               busy,
  barrel_shift_seq_if.slave  bus
);

  localparam int unsigned CNT_W = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic             lr_q, lr_d;
  logic             al_q, al_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;

  // One mux level: shift distance 2^stage, fill chosen by direction/mode
  logic [SHW-1:0]   stage_amt;
  logic [WIDTH-1:0] shift_l, shift_rl, shift_ra, shifted;

  assign stage_amt = SHW'(1) << stage_q;
  assign shift_l   = work_q << stage_amt;
  assign shift_rl  = work_q >> stage_amt;
  assign shift_ra  = $unsigned($signed(work_q) >>> stage_amt);
  assign shifted   = lr_q ? shift_l : (al_q ? shift_ra : shift_rl);

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      work_q      <= '0;
      shamt_q     <= '0;
      lr_q        <= 1'b0;
      al_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      lr_q        <= lr_d;
      al_q        <= al_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    work_d      = work_q;
    shamt_d     = shamt_q;
    lr_d        = lr_q;
    al_d        = al_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      IDLE: begin
        if (!flush && bus.cmd_valid) begin
          work_d  = bus.cmd_data;
          shamt_d = bus.cmd_shamt;
          lr_d    = bus.cmd_lr;
          al_d    = bus.cmd_al;
          stage_d = '0;
          state_d = STAGE;
        end
      end
      STAGE: begin
        if (flush) begin
          state_d = IDLE;
          stage_d = '0;
          work_d  = '0;
        end else begin
          if (shamt_q[stage_q]) begin
            work_d = shifted;
          end
          if (stage_q == LAST_STAGE) begin
            state_d     = DONE;
            stage_d     = '0;
            res_valid_d = 1'b1;
            res_data_d  = work_d;
          end else begin
            stage_d = stage_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (flush || bus.res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          work_d      = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        stage_d     = '0;
        work_d      = '0;
        res_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy          = busy_q;

endmodule
